// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one ALU between two command sources.
// Arbitrates round-robin, latches the winner's opcode and operands onto the
// ALU inputs, waits ALU_LATENCY cycles, then captures the result and pulses
// done to the requester that owns the operation.
module alu_rr_arbiter #(
  parameter int NB_DATA     = 8,
  parameter int NB_OPCODE   = 6,
  parameter int ALU_LATENCY = 1   // legal range 1..15
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req0,
  input  logic [NB_OPCODE-1:0] i_opcode0,
  input  logic [NB_DATA-1:0]   i_op_a0,
  input  logic [NB_DATA-1:0]   i_op_b0,
  output logic                 o_gnt0,
  output logic                 o_done0,
  input  logic                 i_req1,
  input  logic [NB_OPCODE-1:0] i_opcode1,
  input  logic [NB_DATA-1:0]   i_op_a1,
  input  logic [NB_DATA-1:0]   i_op_b1,
  output logic                 o_gnt1,
  output logic                 o_done1,
  output logic [NB_OPCODE-1:0] o_alu_opcode,
  output logic [NB_DATA-1:0]   o_alu_op_A,
  output logic [NB_DATA-1:0]   o_alu_op_B,
  input  logic [NB_DATA-1:0]   i_alu_result,
  output logic [NB_DATA-1:0]   o_result,
  output logic                 o_busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  // Counter is loaded with LATENCY-1 so that the capture happens on the
  // LATENCY-th EXEC cycle.
  localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY - 1);

  logic [0:0]           state_reg;
  logic [3:0]           cnt_reg;
  logic                 owner_reg;
  logic                 last_reg;
  logic [1:0]           gnt_reg;
  logic [1:0]           gnt_next;
  logic [1:0]           done_reg;
  logic [1:0]           done_next;
  logic [NB_OPCODE-1:0] alu_opcode_reg;
  logic [NB_DATA-1:0]   alu_a_reg;
  logic [NB_DATA-1:0]   alu_b_reg;
  logic [NB_DATA-1:0]   result_reg;

  logic [1:0]           req_vec;
  logic                 grant_valid;
  logic                 winner;
  logic                 issue;
  logic                 finish;
  logic [NB_OPCODE-1:0] sel_opcode;
  logic [NB_DATA-1:0]   sel_a;
  logic [NB_DATA-1:0]   sel_b;

  assign req_vec = {i_req1, i_req0};

  // Round-robin pick: a tie goes to the requester that was not served last.
  always_comb begin
    grant_valid = 1'b0;
    winner      = 1'b0;
    if (req_vec == 2'b11) begin
      grant_valid = 1'b1;
      winner      = ~last_reg;
    end else if (req_vec[0]) begin
      grant_valid = 1'b1;
      winner      = 1'b0;
    end else if (req_vec[1]) begin
      grant_valid = 1'b1;
      winner      = 1'b1;
    end
  end

  // Requests are only looked at in IDLE; EXEC ignores them entirely.
  assign issue  = (state_reg == IDLE) && grant_valid;
  assign finish = (state_reg == EXEC) && (cnt_reg == 4'd0);

  assign sel_opcode = winner ? i_opcode1 : i_opcode0;
  assign sel_a      = winner ? i_op_a1   : i_op_a0;
  assign sel_b      = winner ? i_op_b1   : i_op_b0;

  // Per-requester pulse decode: gnt for the winner on issue, done for the
  // owner on capture.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pulse
    assign gnt_next[gi]  = issue  && (winner    == 1'(gi));
    assign done_next[gi] = finish && (owner_reg == 1'(gi));
  end

  // FSM, latency counter and ownership bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
    end else if (state_reg == IDLE) begin
      if (grant_valid) begin
        state_reg <= EXEC;
        cnt_reg   <= LAT_LOAD;
        owner_reg <= winner;
      end
    end else begin
      if (cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end else begin
        last_reg  <= owner_reg;
        state_reg <= IDLE;
      end
    end
  end

  // One-cycle grant and done pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      gnt_reg  <= 2'b00;
      done_reg <= 2'b00;
    end else begin
      gnt_reg  <= gnt_next;
      done_reg <= done_next;
    end
  end

  // ALU input registers: load on issue, otherwise hold the last command.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      alu_opcode_reg <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
    end else if (issue) begin
      alu_opcode_reg <= sel_opcode;
      alu_a_reg      <= sel_a;
      alu_b_reg      <= sel_b;
    end
  end

  // Result capture at the end of the latency window; held until the next one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      result_reg <= '0;
    end else if (finish) begin
      result_reg <= i_alu_result;
    end
  end

  assign o_gnt0       = gnt_reg[0];
  assign o_gnt1       = gnt_reg[1];
  assign o_done0      = done_reg[0];
  assign o_done1      = done_reg[1];
  assign o_alu_opcode = alu_opcode_reg;
  assign o_alu_op_A   = alu_a_reg;
  assign o_alu_op_B   = alu_b_reg;
  assign o_result     = result_reg;
  assign o_busy       = (state_reg == EXEC);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: randomized and directed checks of alu_rr_arbiter
// against a transaction-schedule reference model (events per cycle).
module tb_alu_rr_arbiter;

  localparam int LAT  = 3;
  localparam int NCYC = 1024;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_req0, i_req1;
  logic [5:0] i_opcode0, i_opcode1;
  logic [7:0] i_op_a0, i_op_b0, i_op_a1, i_op_b1;
  logic       o_gnt0, o_done0, o_gnt1, o_done1;
  logic [5:0] o_alu_opcode;
  logic [7:0] o_alu_op_A, o_alu_op_B;
  logic [7:0] i_alu_result;
  logic [7:0] o_result;
  logic       o_busy;

  always #5 clk = ~clk;

  // Behavioural ALU seen by the DUT (combinational from its ALU inputs).
  function automatic logic [7:0] alu_fn(input logic [5:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign i_alu_result = alu_fn(o_alu_opcode, o_alu_op_A, o_alu_op_B);

  alu_rr_arbiter #(.NB_DATA(8), .NB_OPCODE(6), .ALU_LATENCY(LAT)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req0(i_req0), .i_opcode0(i_opcode0), .i_op_a0(i_op_a0), .i_op_b0(i_op_b0),
    .o_gnt0(o_gnt0), .o_done0(o_done0),
    .i_req1(i_req1), .i_opcode1(i_opcode1), .i_op_a1(i_op_a1), .i_op_b1(i_op_b1),
    .o_gnt1(o_gnt1), .o_done1(o_done1),
    .o_alu_opcode(o_alu_opcode), .o_alu_op_A(o_alu_op_A), .o_alu_op_B(o_alu_op_B),
    .i_alu_result(i_alu_result), .o_result(o_result), .o_busy(o_busy)
  );

  // Expected-event schedule, indexed by cycle number.
  bit         e_g0[NCYC], e_g1[NCYC], e_d0[NCYC], e_d1[NCYC], e_busy[NCYC];
  bit         e_alu[NCYC], e_res[NCYC];
  logic [5:0] e_op_v[NCYC];
  logic [7:0] e_a_v[NCYC], e_b_v[NCYC], e_res_v[NCYC];

  // Currently expected held values.
  logic [5:0] x_op;
  logic [7:0] x_a, x_b, x_res;

  // Model of the sharing policy: next cycle in which arbitration may happen,
  // and who was served most recently.
  int cyc;
  int next_arb;
  int last;
  int n_txn;

  // Pending commands of both requesters.
  bit         pend[2];
  logic [5:0] p_op[2];
  logic [7:0] p_a[2], p_b[2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("gnt0",   32'(o_gnt0),       32'(e_g0[cyc]));
    chk("gnt1",   32'(o_gnt1),       32'(e_g1[cyc]));
    chk("done0",  32'(o_done0),      32'(e_d0[cyc]));
    chk("done1",  32'(o_done1),      32'(e_d1[cyc]));
    chk("busy",   32'(o_busy),       32'(e_busy[cyc]));
    chk("alu_op", 32'(o_alu_opcode), 32'(x_op));
    chk("alu_a",  32'(o_alu_op_A),   32'(x_a));
    chk("alu_b",  32'(o_alu_op_B),   32'(x_b));
    chk("result", 32'(o_result),     32'(x_res));
  endtask

  // Move to the next cycle, apply scheduled events, compare every output.
  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    if (e_alu[cyc]) begin
      x_op = e_op_v[cyc];
      x_a  = e_a_v[cyc];
      x_b  = e_b_v[cyc];
    end
    if (e_res[cyc]) x_res = e_res_v[cyc];
    check_all();
    if (e_g0[cyc]) pend[0] = 1'b0;
    if (e_g1[cyc]) pend[1] = 1'b0;
  endtask

  // Drive inputs for the current cycle and predict what the arbiter does.
  task automatic drive_and_model(input int prob, input bit rst);
    int w;
    int td;
    for (int r = 0; r < 2; r++) begin
      if (!pend[r] && ($urandom_range(99) < prob)) begin
        pend[r] = 1'b1;
        p_op[r] = 6'($urandom);
        p_a[r]  = 8'($urandom);
        p_b[r]  = 8'($urandom);
      end
    end
    i_req0    = pend[0];
    i_opcode0 = pend[0] ? p_op[0] : 6'($urandom);
    i_op_a0   = pend[0] ? p_a[0]  : 8'($urandom);
    i_op_b0   = pend[0] ? p_b[0]  : 8'($urandom);
    i_req1    = pend[1];
    i_opcode1 = pend[1] ? p_op[1] : 6'($urandom);
    i_op_a1   = pend[1] ? p_a[1]  : 8'($urandom);
    i_op_b1   = pend[1] ? p_b[1]  : 8'($urandom);
    i_reset   = rst;
    if (rst) begin
      // Everything in flight is abandoned; next cycle is all-zero and idle.
      for (int i = cyc + 1; i < NCYC; i++) begin
        e_g0[i] = 0; e_g1[i] = 0; e_d0[i] = 0; e_d1[i] = 0;
        e_busy[i] = 0; e_alu[i] = 0; e_res[i] = 0;
      end
      x_op = '0; x_a = '0; x_b = '0; x_res = '0;
      next_arb = cyc + 1;
      last = 1;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      $display("cyc %0d: reset asserted", cyc);
    end else if (cyc >= next_arb && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) w = (last == 0) ? 1 : 0;
      else                    w = pend[0] ? 0 : 1;
      if (w == 0) e_g0[cyc + 1] = 1; else e_g1[cyc + 1] = 1;
      e_alu[cyc + 1]  = 1;
      e_op_v[cyc + 1] = p_op[w];
      e_a_v[cyc + 1]  = p_a[w];
      e_b_v[cyc + 1]  = p_b[w];
      for (int k = 1; k <= LAT; k++) e_busy[cyc + k] = 1;
      td = cyc + 1 + LAT;
      if (w == 0) e_d0[td] = 1; else e_d1[td] = 1;
      e_res[td]   = 1;
      e_res_v[td] = alu_fn(p_op[w], p_a[w], p_b[w]);
      next_arb = td;
      last = w;
      n_txn++;
      $display("txn %0d: cyc %0d req%0d op=0x%02h a=0x%02h b=0x%02h -> result 0x%02h at cyc %0d",
               n_txn, cyc, w, p_op[w], p_a[w], p_b[w], e_res_v[td], td);
    end
  endtask

  // Run cycles with no new commands until the model is idle and nothing is pending.
  task automatic wait_idle();
    int k;
    k = 0;
    while (!(cyc >= next_arb && !pend[0] && !pend[1]) && k < 40) begin
      drive_and_model(0, 1'b0);
      advance();
      k++;
    end
    if (k >= 40) begin
      n_cmp++;
      n_bad++;
      $error("FAIL idle_timeout cyc=%0d observed=busy expected=idle", cyc);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_req0 = 0; i_req1 = 0;
    i_opcode0 = 0; i_op_a0 = 0; i_op_b0 = 0;
    i_opcode1 = 0; i_op_a1 = 0; i_op_b1 = 0;
    pend[0] = 0; pend[1] = 0;
    x_op = 0; x_a = 0; x_b = 0; x_res = 0;
    last = 1; n_txn = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    next_arb = 0;
    check_all();  // reset state

    // Directed ADD on requester 0: 0x05 + 0x03.
    pend[0] = 1; p_op[0] = 6'h20; p_a[0] = 8'h05; p_b[0] = 8'h03;
    drive_and_model(0, 1'b0);
    for (int i = 1; i <= LAT + 1; i++) begin
      advance();
      if (i == 1) chk("add_gnt0", 32'(o_gnt0), 32'd1);
      if (i == LAT + 1) begin
        chk("add_done0",  32'(o_done0),  32'd1);
        chk("add_result", 32'(o_result), 32'h08);
      end
      drive_and_model(0, 1'b0);
    end
    advance();

    // Random traffic from both requesters.
    for (int i = 0; i < 300; i++) begin
      drive_and_model(30, 1'b0);
      advance();
    end
    wait_idle();

    // Both requesters hammering: grants must alternate.
    for (int i = 0; i < 40; i++) begin
      drive_and_model(100, 1'b0);
      advance();
    end
    wait_idle();

    // Reset two cycles after the request, in the middle of execution.
    pend[0] = 1; p_op[0] = 6'($urandom); p_a[0] = 8'($urandom); p_b[0] = 8'($urandom);
    drive_and_model(0, 1'b0);   // T
    advance();
    drive_and_model(0, 1'b0);   // T+1
    advance();
    drive_and_model(0, 1'b1);   // T+2: reset
    advance();                  // T+3: all zero
    // Tie right after reset: requester 0 must win.
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1; p_op[r] = 6'($urandom); p_a[r] = 8'($urandom); p_b[r] = 8'($urandom);
    end
    drive_and_model(0, 1'b0);
    advance();
    chk("tie_after_reset_gnt0", 32'(o_gnt0), 32'd1);
    for (int i = 0; i < 60; i++) begin
      drive_and_model(50, 1'b0);
      advance();
    end
    wait_idle();
    drive_and_model(0, 1'b0);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
